// File: rtl/wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// Module      : wb_arbiter_pkg
// Description : Shared widths, state encoding and request bundle for the
//               two-master Wishbone arbiter.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package wb_arbiter_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 128;
  localparam int WB_SEL_W = 16;

  // Encoding doubles as the one-hot grant vector (bit N = master N).
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GNT_M0 = 2'b01,
    GNT_M1 = 2'b10
  } arb_state_t;

  typedef struct packed {
    logic [WB_ADR_W-1:0] adr;
    logic [WB_SEL_W-1:0] sel;
    logic                we;
    logic [WB_DAT_W-1:0] dat;
    logic                cyc;
    logic                stb;
  } wb_req_t;

endpackage

`default_nettype wire

// File: rtl/wb_arb_timeout.sv
// ---------------------------------------------------------------------------
// Module      : wb_arb_timeout
// Description : Slave-response watchdog; fires for one cycle when a strobe
//               has gone unanswered for TIMEOUT_CYCLES cycles.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module wb_arb_timeout
  import wb_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_active,
  input  logic i_resp,
  input  logic i_clear,
  output logic o_timeout
);

  localparam logic [7:0] c_limit = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_count;

  assign o_timeout = i_active && !i_resp && (r_count == c_limit);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= 8'd0;
    end else if (i_clear || !i_active || i_resp || o_timeout) begin
      r_count <= 8'd0;
    end else begin
      r_count <= r_count + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// Module      : wb_arbiter
// Description : Two-master round-robin Wishbone arbiter with non-splitting
//               grants. Optional watchdog enabled by WB_ARBITER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [WB_ADR_W-1:0] i_m0_adr,
  input  logic [WB_SEL_W-1:0] i_m0_sel,
  input  logic                i_m0_we,
  input  logic [WB_DAT_W-1:0] i_m0_dat,
  input  logic                i_m0_cyc,
  input  logic                i_m0_stb,
  input  logic [WB_ADR_W-1:0] i_m1_adr,
  input  logic [WB_SEL_W-1:0] i_m1_sel,
  input  logic                i_m1_we,
  input  logic [WB_DAT_W-1:0] i_m1_dat,
  input  logic                i_m1_cyc,
  input  logic                i_m1_stb,
  output logic [WB_DAT_W-1:0] o_m0_dat,
  output logic                o_m0_ack,
  output logic                o_m0_err,
  output logic [WB_DAT_W-1:0] o_m1_dat,
  output logic                o_m1_ack,
  output logic                o_m1_err,
  output logic [WB_ADR_W-1:0] o_wb_adr,
  output logic [WB_SEL_W-1:0] o_wb_sel,
  output logic                o_wb_we,
  output logic [WB_DAT_W-1:0] o_wb_dat,
  output logic                o_wb_cyc,
  output logic                o_wb_stb,
  input  logic [WB_DAT_W-1:0] i_wb_dat,
  input  logic                i_wb_ack,
  input  logic                i_wb_err,
  output logic [1:0]          o_grant
);

  arb_state_t r_state;
  arb_state_t w_next_state;
  logic       r_last_m1;
  logic       w_timeout;
  wb_req_t    w_m0_req;
  wb_req_t    w_m1_req;
  wb_req_t    w_req;

  assign w_m0_req = '{adr: i_m0_adr, sel: i_m0_sel, we: i_m0_we,
                      dat: i_m0_dat, cyc: i_m0_cyc, stb: i_m0_stb};
  assign w_m1_req = '{adr: i_m1_adr, sel: i_m1_sel, we: i_m1_we,
                      dat: i_m1_dat, cyc: i_m1_cyc, stb: i_m1_stb};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_last_m1 <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (w_next_state != IDLE) begin
        r_last_m1 <= (w_next_state == GNT_M1);
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (i_m0_cyc && i_m1_cyc) begin
          w_next_state = r_last_m1 ? GNT_M0 : GNT_M1;
        end else if (i_m0_cyc) begin
          w_next_state = GNT_M0;
        end else if (i_m1_cyc) begin
          w_next_state = GNT_M1;
        end
      end
      // A grant is only released when its owner drops cyc; hand over directly.
      GNT_M0: begin
        if (!i_m0_cyc) begin
          w_next_state = i_m1_cyc ? GNT_M1 : IDLE;
        end
      end
      GNT_M1: begin
        if (!i_m1_cyc) begin
          w_next_state = i_m0_cyc ? GNT_M0 : IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_req    = '0;
    o_m0_dat = '0;
    o_m0_ack = 1'b0;
    o_m0_err = 1'b0;
    o_m1_dat = '0;
    o_m1_ack = 1'b0;
    o_m1_err = 1'b0;
    case (r_state)
      GNT_M0: begin
        w_req    = w_m0_req;
        o_m0_dat = i_wb_dat;
        o_m0_ack = i_wb_ack;
        o_m0_err = i_wb_err || w_timeout;
      end
      GNT_M1: begin
        w_req    = w_m1_req;
        o_m1_dat = i_wb_dat;
        o_m1_ack = i_wb_ack;
        o_m1_err = i_wb_err || w_timeout;
      end
      default: ;
    endcase
  end

  // A timed-out strobe is withdrawn from the slave for the error cycle.
  assign o_wb_adr = w_req.adr;
  assign o_wb_sel = w_req.sel;
  assign o_wb_we  = w_req.we;
  assign o_wb_dat = w_req.dat;
  assign o_wb_cyc = w_req.cyc && !w_timeout;
  assign o_wb_stb = w_req.stb && !w_timeout;
  assign o_grant  = r_state;

`ifdef WB_ARBITER_TIMEOUT_EN
  wb_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_active  ((r_state != IDLE) && w_req.stb),
    .i_resp    (i_wb_ack || i_wb_err),
    .i_clear   (w_next_state != r_state),
    .o_timeout (w_timeout)
  );
`else
  localparam int c_timeout_unused = TIMEOUT_CYCLES;
  assign w_timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// Module      : tb_wb_arbiter
// Description : Directed self-checking bench for wb_arbiter.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wb_arbiter;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [31:0]  i_m0_adr, i_m1_adr, o_wb_adr;
  logic [15:0]  i_m0_sel, i_m1_sel, o_wb_sel;
  logic         i_m0_we, i_m1_we, o_wb_we;
  logic [127:0] i_m0_dat, i_m1_dat, o_wb_dat, i_wb_dat, o_m0_dat, o_m1_dat;
  logic         i_m0_cyc, i_m0_stb, i_m1_cyc, i_m1_stb;
  logic         o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
  logic         o_wb_cyc, o_wb_stb, i_wb_ack, i_wb_err;
  logic [1:0]   o_grant;

  int n_checks = 0;
  int n_pass   = 0;
  int n_errs;

  always #5 i_clk = ~i_clk;

  wb_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_m0_adr(i_m0_adr), .i_m0_sel(i_m0_sel), .i_m0_we(i_m0_we),
    .i_m0_dat(i_m0_dat), .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb),
    .i_m1_adr(i_m1_adr), .i_m1_sel(i_m1_sel), .i_m1_we(i_m1_we),
    .i_m1_dat(i_m1_dat), .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb),
    .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err),
    .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err),
    .o_wb_adr(o_wb_adr), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
    .o_wb_dat(o_wb_dat), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .o_grant(o_grant)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_cyc(input logic m0, input logic m1);
    i_m0_cyc = m0; i_m0_stb = m0;
    i_m1_cyc = m1; i_m1_stb = m1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1;
    i_m0_adr = 32'h0000_0100; i_m0_sel = 16'hFFFF; i_m0_we = 1'b1;
    i_m0_dat = 128'hA5A5;
    i_m1_adr = 32'h0000_0200; i_m1_sel = 16'h00FF; i_m1_we = 1'b0;
    i_m1_dat = 128'h5A5A;
    set_cyc(1'b0, 1'b0);
    i_wb_dat = '0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
    step(); step();
    i_rst = 1'b0;

    // Reset state
    check("rst_grant", o_grant, 2'b00);
    check("rst_wb_cyc", o_wb_cyc, 1'b0);
    check("rst_wb_adr", o_wb_adr, 32'h0);
    check("rst_m0_ack", o_m0_ack, 1'b0);

    // Single M0 request, one-cycle latency, same-cycle ack routing
    set_cyc(1'b1, 1'b0);
    #1 check("m0_latency", o_grant, 2'b00);
    step();
    check("m0_grant", o_grant, 2'b01);
    check("m0_wb_adr", o_wb_adr, 32'h100);
    check("m0_wb_dat", o_wb_dat, 128'hA5A5);
    check("m0_wb_we", o_wb_we, 1'b1);
    i_wb_ack = 1'b1; i_wb_dat = 128'hF0801003;
    #1;
    check("m0_ack", o_m0_ack, 1'b1);
    check("m0_dat", o_m0_dat, 128'hF0801003);
    check("m1_dat_iso", o_m1_dat, 128'h0);
    i_wb_ack = 1'b0;
    set_cyc(1'b0, 1'b0);
    step();
    check("m0_release", o_grant, 2'b00);

    // Tie after reset goes to M0, then direct hand-over to M1
    do_reset();
    set_cyc(1'b1, 1'b1);
    step();
    check("tie_m0", o_grant, 2'b01);
    i_m0_cyc = 1'b0; i_m0_stb = 1'b0;
    step();
    check("handover_m1", o_grant, 2'b10);
    check("handover_adr", o_wb_adr, 32'h200);

    // Isolation during GNT_M1, M0 waiting
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1;
    i_wb_ack = 1'b1;
    #1;
    check("iso_m1_ack", o_m1_ack, 1'b1);
    check("iso_m0_ack", o_m0_ack, 1'b0);
    check("hold_m1", o_grant, 2'b10);

    // Reset mid-transfer
    i_wb_err = 1'b1;
    i_rst = 1'b1;
    step();
    check("midrst_grant", o_grant, 2'b00);
    check("midrst_wb_cyc", o_wb_cyc, 1'b0);
    check("midrst_m1_ack", o_m1_ack, 1'b0);
    check("midrst_m1_err", o_m1_err, 1'b0);
    i_rst = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0;

    // Round-robin over three ties: M0, M1, M0
    set_cyc(1'b1, 1'b1);
    step(); check("rr1", o_grant, 2'b01);
    set_cyc(1'b0, 1'b0);
    step(); check("rr1_idle", o_grant, 2'b00);
    set_cyc(1'b1, 1'b1);
    step(); check("rr2", o_grant, 2'b10);
    set_cyc(1'b0, 1'b0);
    step(); check("rr2_idle", o_grant, 2'b00);
    set_cyc(1'b1, 1'b1);
    step(); check("rr3", o_grant, 2'b01);
    set_cyc(1'b0, 1'b0);
    step();

    // Responses in IDLE are dropped
    i_wb_ack = 1'b1; i_wb_err = 1'b1;
    #1;
    check("idle_m0_ack", o_m0_ack, 1'b0);
    check("idle_m1_ack", o_m1_ack, 1'b0);
    check("idle_m0_err", o_m0_err, 1'b0);
    check("idle_wb_stb", o_wb_stb, 1'b0);
    check("idle_wb_we", o_wb_we, 1'b0);
    i_wb_ack = 1'b0; i_wb_err = 1'b0;

    // Unanswered strobe
    set_cyc(1'b1, 1'b0);
    step();
`ifdef WB_ARBITER_TIMEOUT_EN
    check("to_c1", o_m0_err, 1'b0);
    step(); check("to_c2", o_m0_err, 1'b0);
    step(); check("to_c3", o_m0_err, 1'b0);
    step();
    check("to_err", o_m0_err, 1'b1);
    check("to_wb_cyc", o_wb_cyc, 1'b0);
    check("to_wb_stb", o_wb_stb, 1'b0);
    step();
    check("to_clear_err", o_m0_err, 1'b0);
    check("to_clear_cyc", o_wb_cyc, 1'b1);
`else
    n_errs = 0;
    for (int i = 0; i < 300; i++) begin
      if (o_m0_err || !o_wb_cyc) n_errs++;
      step();
    end
    check("no_timeout", n_errs, 0);
    check("still_granted", o_grant, 2'b01);
`endif
    set_cyc(1'b0, 1'b0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
